// File: rtl/vga_pkg.sv
// Shared constants for the VGA framebuffer fetch path: default 640x480@60
// timing, framebuffer geometry, BRAM widths and colour field positions.
package vga_pkg;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 18;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int                VGA_SCALE_SHIFT = 2;
  localparam int                VGA_FB_WIDTH    = 160;
  localparam logic [ADDR_W-1:0] VGA_FB_BASE     = 15'h0000;

  // Colour fields inside the framebuffer word (RGB332 in the low byte)
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Total length of a line or frame: visible + front porch + sync + back porch
  function automatic int span_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // First count of the sync pulse
  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  // First count after the sync pulse
  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

endpackage

// File: rtl/vga_fb_fetch_if.sv
// BRAM port B bundle between the display fetch logic and the framebuffer.
interface vga_fb_fetch_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] addrb;
  logic              web;
  logic [WORD_W-1:0] dinb;
  logic [WORD_W-1:0] doutb;

  modport master (output addrb, output web, output dinb, input doutb);
  modport slave  (input addrb, input web, input dinb, output doutb);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel tick at half the system clock, h/v counters and the
// combinational decode of active/sync/blank at the counter stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int H_CNT_W = $clog2(H_TOTAL),
  localparam int V_CNT_W = $clog2(V_TOTAL)
)(
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               line_end,
  output logic               last_line,
  output logic               active,
  output logic               hs,
  output logic               vs,
  output logic               vb,
  output logic               frame_start
);

  localparam logic [H_CNT_W-1:0] H_ONE      = H_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] V_ONE      = V_CNT_W'(1);
  localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT_C    = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_ACT_C    = V_CNT_W'(V_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START_C = H_CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [H_CNT_W-1:0] HS_END_C   = H_CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [V_CNT_W-1:0] VS_START_C = V_CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [V_CNT_W-1:0] VS_END_C   = V_CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  assign line_end  = (h_cnt == H_LAST);
  assign last_line = (v_cnt == V_LAST);

  // Pixel tick: toggles every clock so the first tick lands on the second clock after reset
  always_ff @(posedge clk) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= ~pix_en;
  end

  // Raster position, advanced once per pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= last_line ? '0 : v_cnt + V_ONE;
      end else begin
        h_cnt <= h_cnt + H_ONE;
      end
    end
  end

  // Frame marker: high for the single clock after the counters wrap to (0,0)
  always_ff @(posedge clk) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= pix_en && line_end && last_line;
  end

  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs     = !((h_cnt >= HS_START_C) && (h_cnt < HS_END_C));
  assign vs     = !((v_cnt >= VS_START_C) && (v_cnt < VS_END_C));
  assign vb     = (v_cnt >= V_ACT_C);

endmodule

// File: rtl/vga_fb_fetch.sv
// Display-side framebuffer reader: drives BRAM port B read-only, scales the
// framebuffer up by 2^SCALE_SHIFT in each axis and emits registered RGB and
// syncs, all lagging the raster counters by two pixel ticks.
module vga_fb_fetch
  import vga_pkg::*;
#(
  parameter int                H_ACTIVE    = VGA_H_ACTIVE,
  parameter int                H_FP        = VGA_H_FP,
  parameter int                H_SYNC      = VGA_H_SYNC,
  parameter int                H_BP        = VGA_H_BP,
  parameter int                V_ACTIVE    = VGA_V_ACTIVE,
  parameter int                V_FP        = VGA_V_FP,
  parameter int                V_SYNC      = VGA_V_SYNC,
  parameter int                V_BP        = VGA_V_BP,
  parameter int                SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int                FB_WIDTH    = VGA_FB_WIDTH,
  parameter logic [ADDR_W-1:0] FB_BASE     = VGA_FB_BASE,
  localparam int H_CNT_W = $clog2(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int V_CNT_W = $clog2(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
)(
  input  logic                   clka,
  input  logic                   reset,
  input  logic                   display_en,
  vga_fb_fetch_if.master         bram,
  output logic [R_MSB-R_LSB:0]   vga_r,
  output logic [G_MSB-G_LSB:0]   vga_g,
  output logic [B_MSB-B_LSB:0]   vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vblank,
  output logic                   frame_start
);

  localparam logic [ADDR_W-1:0]  FB_WIDTH_C = ADDR_W'(FB_WIDTH);
  localparam logic [V_CNT_W-1:0] V_ONE      = V_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] V_ACT_C    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] ROW_MASK   = V_CNT_W'((1 << SCALE_SHIFT) - 1);

  logic               pix_en;
  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               line_end;
  logic               last_line;
  logic               active;
  logic               hs;
  logic               vs;
  logic               vb;

  logic [ADDR_W-1:0]  row_base;
  logic [ADDR_W-1:0]  addr_p0;
  logic [V_CNT_W-1:0] v_next;
  logic               row_step;
  logic [WORD_W-1:0]  fb_word;
  logic               unused_hi;

  logic vld_p0;
  logic hs_p0;
  logic vs_p0;
  logic vb_p0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clka),
    .rst         (reset),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .line_end    (line_end),
    .last_line   (last_line),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .vb          (vb),
    .frame_start (frame_start)
  );

  // Port B is read-only from this side
  assign bram.web   = 1'b0;
  assign bram.dinb  = '0;
  assign bram.addrb = addr_p0;

  // Only the low byte carries colour; the upper bits of the word are ignored
  assign fb_word   = bram.doutb;
  assign unused_hi = ^fb_word[WORD_W-1:R_MSB+1];

  // A new framebuffer row starts every 2^SCALE_SHIFT visible lines
  assign v_next   = v_cnt + V_ONE;
  assign row_step = (v_next < V_ACT_C) && ((v_next & ROW_MASK) == '0);

  // Row base: start address of the framebuffer row for the line being scanned
  always_ff @(posedge clka) begin
    if (reset) begin
      row_base <= FB_BASE;
    end else if (pix_en && line_end) begin
      if (last_line)     row_base <= FB_BASE;
      else if (row_step) row_base <= row_base + FB_WIDTH_C;
    end
  end

  // ---- stage p0: BRAM address issue and alignment of the decoded timing ----
  // Address generator: one framebuffer word per 2^SCALE_SHIFT pixels, held in blanking
  always_ff @(posedge clka) begin
    if (reset)                addr_p0 <= FB_BASE;
    else if (pix_en && active) addr_p0 <= row_base + ADDR_W'(h_cnt >> SCALE_SHIFT);
  end

  // Timing flags follow the address so they meet the BRAM data one tick later
  always_ff @(posedge clka) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      hs_p0  <= 1'b1;
      vs_p0  <= 1'b1;
      vb_p0  <= 1'b0;
    end else if (pix_en) begin
      vld_p0 <= active;
      hs_p0  <= hs;
      vs_p0  <= vs;
      vb_p0  <= vb;
    end
  end

  // ---- stage p1: registered outputs, BRAM data arrives on the clock before ----
  // Output register: colour only inside the visible area and while display is enabled
  always_ff @(posedge clka) begin
    if (reset) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vblank    <= 1'b0;
    end else if (pix_en) begin
      if (vld_p0 && display_en) begin
        vga_r <= fb_word[R_MSB:R_LSB];
        vga_g <= fb_word[G_MSB:G_LSB];
        vga_b <= fb_word[B_MSB:B_LSB];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
      vga_hsync <= hs_p0;
      vga_vsync <= vs_p0;
      vblank    <= vb_p0;
    end
  end

endmodule

// File: doc/vga_fb_fetch.md
Name: vga_fb_fetch

Overview:
- Display-side consumer of the dual-port framebuffer BRAM.
- Drives BRAM port B read-only: port B address out, port B read data in, port B write enable held low.
- Generates 640x480@60 VGA timing from the 50 MHz system clock, with one pixel tick every 2 clocks.
- Fetches one 18-bit word per scaled framebuffer pixel and drives registered RGB and sync outputs.
- CPU writes through port A; this block never writes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE_SHIFT, 2, log2 of screen pixels per framebuffer pixel in each axis
- FB_WIDTH, 160, framebuffer words per row
- FB_BASE, 15'h0000, BRAM word address of pixel (0,0)

Ports:
- clka  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- display_en  in  1  1 = show framebuffer, 0 = force RGB to 0 (timing keeps running)
- addrb  out  15  BRAM port B address
- web  out  1  BRAM port B write enable, constant 0
- dinb  out  18  BRAM port B write data, constant 0
- doutb  in  18  BRAM port B read data, valid 1 clock after addrb
- vga_r  out  3  red, from word[7:5]
- vga_g  out  3  green, from word[4:2]
- vga_b  out  2  blue, from word[1:0]
- vga_hsync  out  1  active-low horizontal sync
- vga_vsync  out  1  active-low vertical sync
- vblank  out  1  1 while the output stage is in vertical blanking (CPU-side write window)
- frame_start  out  1  one-clock pulse when h=0, v=0 is reached

Behaviour:
- Reset (synchronous, active-high) state:
  - pix_en phase = 0; h_cnt = 0; v_cnt = 0; row_base = FB_BASE; addrb = FB_BASE.
  - RGB = 0; hsync = 1; vsync = 1; vblank = 0; frame_start = 0.
  - Alignment pipeline is cleared to blank, syncs inactive.
- Pixel tick: pix_en toggles every clock and is 1 on the second clock after reset release. Counters, address and output stages advance only on pix_en clocks.
- h_cnt counts 0..H_TOTAL-1 (800), then wraps to 0 and advances v_cnt. v_cnt counts 0..V_TOTAL-1 (525), then wraps to 0.
- Timing decode at counter stage:
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hs = !(656<=h<752).
  - vs = !(490<=v<492).
  - vb = v>=V_ACTIVE.
- Address generation, on each pix_en clock with active=1:
  - addrb <= row_base + (h_cnt>>SCALE_SHIFT), computed modulo 2^15.
  - addrb holds its value outside active.
  - No multiplier is used.
- row_base update on h wrap:
  - If v wraps, row_base <= FB_BASE.
  - Else if (v+1)<V_ACTIVE and (v+1)[SCALE_SHIFT-1:0]==0, row_base += FB_WIDTH.
  - Otherwise row_base holds.
- Data capture: doutb is valid the clock after addrb updates, which is the non-pix_en clock. On the next pix_en clock the output register loads doutb[7:0] if (delayed active && display_en), else 0. doutb[17:8] is ignored.
- Alignment: hs, vs, vb and active pass through a 2-stage pix_en shift register. All outputs lag the counters by exactly 2 pixel ticks (4 clocks) and are mutually aligned.
- frame_start: 1 for one clock, on the pix_en clock where the counters become (0,0). It is not delayed.
- display_en is sampled at the output stage. Toggling it mid-line affects only later pixels.
- Reset mid-frame restarts at (0,0) on the next clock. Outputs go to their reset values the same clock; no partial pulse is stretched.

Decomposition:
- Package vga_pkg:
  - Timing constants and derived H_TOTAL=800, V_TOTAL=525.
  - Sync start/end values.
  - RGB field bit positions within the framebuffer word.
- Sub-module vga_timing_gen:
  - Contains pix_en, h_cnt/v_cnt, and hs/vs/vb/active/frame_start decode.
  - vga_fb_fetch keeps the address generator, row_base and the alignment/output stages.

Test Plan:
- Reset: hold reset 5 clocks, check outputs 1 clock in. Required: vga_hsync=1, vga_vsync=1, RGB=0, addrb=0, frame_start=0, web=0.
- Line timing: release reset and measure. Required:
  - vga_hsync low for 192 clocks, period 1600 clocks.
  - First falling edge 1316 clocks after reset release (656 ticks + 2-tick lag).
- Frame timing:
  - vga_vsync low for 2 lines (3200 clocks) per 840000 clocks.
  - frame_start period 840000 clocks.
  - vblank high 45 lines.
- Address sequence:
  - Line 0 addrb steps 0,1,...,159, each value held for 4 ticks.
  - Lines 0-3 repeat 0..159; line 4 starts at 160.
  - Last active address is 19199.
  - addrb holds during blanking.
- Pixel alignment: BRAM model preloaded with word[5]=18'h000E0, all others 0. Required: vga_r=7 only on screen x=20..23, lines 0..3; all other RGB=0; the pixel is aligned with the hsync offsets above.
- display_en and reset mid-frame:
  - Drop display_en at line 100: RGB=0 from then on while syncs are unchanged.
  - Assert reset at line 300 for 1 clock: counters, row_base and addrb return to 0, and the next frame_start arrives exactly 840000 clocks later.
